// File: rtl/hdmi_clk_sequencer.sv
// Power-up / recovery sequencer for the HDMI PLL + CLKDIV pair, running on the crystal clock.
// Pulses PLL reset, qualifies lock, then releases divider and pixel-domain resets in order.
module hdmi_clk_sequencer #(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 27000,
    parameter int unsigned STABLE_CYCLES = 2700,
    parameter int unsigned DIV_CYCLES    = 64,
    parameter int unsigned MAX_RETRY     = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic       div_resetn,
    output logic       video_reset_n,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retry_count
);

    localparam int unsigned MAX_A   = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_B   = (STABLE_CYCLES > DIV_CYCLES) ? STABLE_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_SETTLE,
        S_DIV_START,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic   [CW-1:0] cnt_q, cnt_d;
    logic   [CW-1:0] load_val;
    logic   [2:0]    retry_q, retry_d;
    logic            fail_q, fail_d;
    logic            lock_meta_q, lock_meta_d;
    logic            lock_s_q, lock_s_d;
    logic            pll_reset_q, pll_reset_d;
    logic            div_resetn_q, div_resetn_d;
    logic            video_reset_n_q, video_reset_n_d;
    logic            ready_q, ready_d;
    logic            inc_retry;
    logic            expired;

    always_comb begin
        lock_meta_d = lock;
        lock_s_d    = lock_meta_q;
        state_d     = state_q;
        retry_d     = retry_q;
        fail_d      = fail_q;
        inc_retry   = 1'b0;
        expired     = (cnt_q == CW'(1));
        cnt_d       = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;

        if (restart) begin
            state_d = S_RESET_PLL;
            fail_d  = 1'b0;
        end else begin
            case (state_q)
                S_RESET_PLL: if (expired) state_d = S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = S_SETTLE;
                    end else if (expired) begin
                        state_d   = S_RESET_PLL;
                        inc_retry = 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (!lock_s_q)    state_d = S_WAIT_LOCK;
                    else if (expired) state_d = S_DIV_START;
                end
                S_DIV_START: begin
                    if (!lock_s_q) begin
                        state_d   = S_RESET_PLL;
                        inc_retry = 1'b1;
                    end else if (expired) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!lock_s_q) begin
                        state_d   = S_RESET_PLL;
                        inc_retry = 1'b1;
                    end
                end
                default: state_d = S_RESET_PLL;
            endcase
        end

        // An increment that would pass MAX_RETRY raises fail instead of counting.
        if (inc_retry) begin
            if ({29'd0, retry_q} >= MAX_RETRY) fail_d  = 1'b1;
            else if (retry_q != 3'd7)          retry_d = retry_q + 3'd1;
        end

        case (state_d)
            S_RESET_PLL: load_val = CW'(RESET_CYCLES);
            S_WAIT_LOCK: load_val = CW'(LOCK_TIMEOUT);
            S_SETTLE:    load_val = CW'(STABLE_CYCLES);
            S_DIV_START: load_val = CW'(DIV_CYCLES);
            default:     load_val = '0;
        endcase

        if (restart || (state_d != state_q)) cnt_d = load_val;
        if (state_d == S_RUN && state_q != S_RUN) retry_d = '0;

        // Outputs are decoded from the next state so they register alongside it.
        pll_reset_d     = (state_d == S_RESET_PLL);
        div_resetn_d    = (state_d == S_DIV_START) || (state_d == S_RUN);
        video_reset_n_d = (state_d == S_RUN);
        ready_d         = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_q     <= 1'b0;
            lock_s_q        <= 1'b0;
            state_q         <= S_RESET_PLL;
            cnt_q           <= CW'(RESET_CYCLES);
            retry_q         <= '0;
            fail_q          <= 1'b0;
            pll_reset_q     <= 1'b1;
            div_resetn_q    <= 1'b0;
            video_reset_n_q <= 1'b0;
            ready_q         <= 1'b0;
        end else begin
            lock_meta_q     <= lock_meta_d;
            lock_s_q        <= lock_s_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            retry_q         <= retry_d;
            fail_q          <= fail_d;
            pll_reset_q     <= pll_reset_d;
            div_resetn_q    <= div_resetn_d;
            video_reset_n_q <= video_reset_n_d;
            ready_q         <= ready_d;
        end
    end

    assign pll_reset     = pll_reset_q;
    assign div_resetn    = div_resetn_q;
    assign video_reset_n = video_reset_n_q;
    assign ready         = ready_q;
    assign fail          = fail_q;
    assign retry_count   = retry_q;

endmodule

// File: tb/tb_hdmi_clk_sequencer.sv
// Scoreboard bench for hdmi_clk_sequencer: every output change is matched against a queued
// {outputs, cycle} expectation; cycle = posedges since the last reset_n release.
module tb_hdmi_clk_sequencer;

    localparam int unsigned LT = 100;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       lock    = 1'b0;
    logic       restart = 1'b0;
    logic       pll_reset, div_resetn, video_reset_n, ready, fail;
    logic [2:0] retry_count;

    typedef struct {
        logic [7:0]  vec;
        int unsigned at;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;
    logic [7:0]  mon_prev = 'x;
    event        sample_ev;

    hdmi_clk_sequencer #(
        .RESET_CYCLES (16),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(2700),
        .DIV_CYCLES   (64),
        .MAX_RETRY    (7)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .lock         (lock),
        .restart      (restart),
        .pll_reset    (pll_reset),
        .div_resetn   (div_resetn),
        .video_reset_n(video_reset_n),
        .ready        (ready),
        .fail         (fail),
        .retry_count  (retry_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // vector layout: pll_reset, div_resetn, video_reset_n, ready, fail, retry_count[2:0]
    function automatic logic [7:0] mk(input logic p, input logic d, input logic v,
                                      input logic r, input logic f, input logic [2:0] c);
        return {p, d, v, r, f, c};
    endfunction

    task automatic expect_at(input string name, input int unsigned at, input logic [7:0] v);
        exp_t e;
        e.vec  = v;
        e.at   = at;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int unsigned n);
        int guard = 0;
        while (cyc < n) begin
            @(negedge clk);
            guard++;
            if (guard > 20000) begin
                checks++;
                errors++;
                $display("FAIL wait_cyc: cycle %0d, required to reach %0d", cyc, n);
                return;
            end
        end
    endtask

    // Reset is dropped between clock edges and sampled 1 ns later, before any edge.
    task automatic drop_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        lock    = 1'b0;
        restart = 1'b0;
        #1 ->sample_ev;
    endtask

    task automatic do_reset();
        drop_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin : monitor
        logic [7:0] cur;
        exp_t       e;
        forever begin
            @(negedge clk or sample_ev);
            cur = {pll_reset, div_resetn, video_reset_n, ready, fail, retry_count};
            if (cur !== mon_prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %b at cycle %0d, required no change", cur, cyc);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.vec || cyc != e.at) begin
                        errors++;
                        $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                                 e.name, cur, cyc, e.vec, e.at);
                    end
                end
                mon_prev = cur;
            end
        end
    end

    initial begin : stimulus
        exp_t e;

        // Nominal bring-up, lock raised at cycle 100
        expect_at("reset_values",      0,    mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        expect_at("pll_reset_release", 16,   mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        expect_at("div_release",       2803, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
        expect_at("run_entry",         2867, mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_cyc(100);
        lock = 1'b1;

        // One-cycle lock drop in RUN
        expect_at("run_lock_loss",     3003, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
        expect_at("reseq_wait_lock",   3019, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
        expect_at("reseq_div",         5720, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1));
        expect_at("reseq_run_clear",   5784, mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0));
        wait_cyc(3000);
        lock = 1'b0;
        wait_cyc(3001);
        lock = 1'b1;
        wait_cyc(5800);

        // Async reset from RUN, then a 3-cycle lock glitch at SETTLE cycle 1000
        expect_at("async_reset_run1",  0,    mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        expect_at("glitch_wait_lock",  16,   mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        expect_at("glitch_div",        3728, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
        expect_at("glitch_run",        3792, mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0));
        do_reset();
        wait_cyc(20);
        lock = 1'b1;
        wait_cyc(1022);
        lock = 1'b0;
        wait_cyc(1025);
        lock = 1'b1;
        wait_cyc(3850);

        // Lock held low: a timeout every 16+LT cycles, fail on the 8th
        expect_at("async_reset_run2",  0,    mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        expect_at("to_wait_lock_0",    16,   mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        for (int k = 1; k <= 7; k++) begin
            expect_at($sformatf("timeout_%0d", k), (16 + LT) * k,
                      mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'(k)));
            expect_at($sformatf("to_wait_lock_%0d", k), (16 + LT) * k + 16,
                      mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'(k)));
        end
        expect_at("timeout_8_fail",    928,  mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7));
        expect_at("to_wait_lock_8",    944,  mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7));
        expect_at("fail_div",          3653, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7));
        expect_at("fail_run",          3717, mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0));
        do_reset();
        wait_cyc(950);
        lock = 1'b1;
        wait_cyc(3750);

        // With fail set: lock loss, then restart while in DIV_START
        expect_at("fail_lock_loss",    3803, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1));
        expect_at("fail_wait_lock",    3819, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1));
        expect_at("fail_div2",         6520, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1));
        expect_at("restart_in_div",    6531, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
        expect_at("restart_wait_lock", 6547, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
        expect_at("restart_div",       9248, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1));
        expect_at("restart_run",       9312, mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0));
        wait_cyc(3800);
        lock = 1'b0;
        wait_cyc(3801);
        lock = 1'b1;
        wait_cyc(6530);
        restart = 1'b1;
        wait_cyc(6531);
        restart = 1'b0;
        wait_cyc(9400);

        // Final async reset in RUN, held low to the end
        expect_at("async_reset_run3",  0,    mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        drop_reset();
        repeat (4) @(negedge clk);

        while (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: event missing, required %b at cycle %0d", e.name, e.vec, e.at);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
